// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the MEM-stage data-memory controller.
// Size codes, FSM states, the latched request bundle and lane helpers.
package mem_pkg;

  localparam logic [1:0] MEM_SZ_BYTE = 2'b00;
  localparam logic [1:0] MEM_SZ_HALF = 2'b01;
  localparam logic [1:0] MEM_SZ_WORD = 2'b10;
  localparam logic [1:0] MEM_SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } memState_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sgn;
    logic        rd;
    logic        wr;
  } memReq_t;

  function automatic logic [3:0] laneMask(
    input logic [1:0] size,
    input logic [1:0] a
  );
    logic [3:0] m;
    m = 4'b0000;
    unique case (1'b1)
      size == MEM_SZ_BYTE: m = 4'b0001 << a;
      size == MEM_SZ_HALF: m = a[1] ? 4'b1100 : 4'b0011;
      size == MEM_SZ_WORD: m = 4'b1111;
      size == MEM_SZ_RSVD: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Replicate narrow store data onto every lane it could land in.
  function automatic logic [31:0] storeSteer(
    input logic [1:0]  size,
    input logic [31:0] d
  );
    logic [31:0] s;
    s = d;
    unique case (1'b1)
      size == MEM_SZ_BYTE: s = {4{d[7:0]}};
      size == MEM_SZ_HALF: s = {2{d[15:0]}};
      size == MEM_SZ_WORD: s = d;
      size == MEM_SZ_RSVD: s = d;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] loadExtend(
    input logic [31:0] w,
    input logic [1:0]  size,
    input logic [1:0]  a,
    input logic        sgn
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[8*a +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    r = '0;
    unique case (1'b1)
      size == MEM_SZ_BYTE: r = {{24{sgn & b[7]}}, b};
      size == MEM_SZ_HALF: r = {{16{sgn & h[15]}}, h};
      size == MEM_SZ_WORD: r = w;
      size == MEM_SZ_RSVD: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port word RAM with four byte-enable write lanes.
// Read is synchronous; read and write share one address.
module data_mem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter bit INIT_ZERO   = 1'b1,
  localparam int AW         = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  localparam logic [31:0] INIT_WORD = INIT_ZERO ? 32'h0 : 32'hx;

  logic [31:0] mem [DEPTH_WORDS] = '{default: INIT_WORD};

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data-memory controller: sized loads/stores, wait states,
// alignment/range checking and sign/zero extension around a byte-lane RAM.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0,
  parameter bit INIT_ZERO   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Address,
  input  logic [31:0] WrData,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [1:0]  MemSize,
  input  logic        MemSgn,
  output logic        Ready,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] RdData,
  output logic        Err
);

  localparam int         AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  memState_t     state, nextState;
  memReq_t       req;
  logic [3:0]    cnt, nextCnt;
  logic          accept;
  logic          reqErr;
  logic          arrWe;
  logic [3:0]    arrBe;
  logic [AW-1:0] arrAddr;
  logic [31:0]   arrWData;
  logic [31:0]   arrRData;

  assign accept = (state == ST_IDLE) && (MemRd || MemWr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      req   <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
      if (accept) begin
        req <= '{addr: Address, wdata: WrData, size: MemSize,
                 sgn: MemSgn, rd: MemRd, wr: MemWr};
      end
    end
  end

  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (MemRd || MemWr) begin
          nextCnt   = WS;
          nextState = (WS == 4'd0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt <= 4'd1) nextState = ST_RESP;
        else nextCnt = cnt - 4'd1;
      end
      ST_RESP: nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    reqErr = 1'b0;
    if (req.rd && req.wr) reqErr = 1'b1;
    if (req.size == MEM_SZ_RSVD) reqErr = 1'b1;
    if (req.size == MEM_SZ_HALF && req.addr[0]) reqErr = 1'b1;
    if (req.size == MEM_SZ_WORD && req.addr[1:0] != 2'b00) reqErr = 1'b1;
    if ((req.addr >> (AW + 2)) != '0) reqErr = 1'b1;
  end

  // In IDLE the array reads the live address so a zero-wait load
  // has its word ready in the very next (RESP) cycle.
  assign arrAddr  = (state == ST_IDLE) ? Address[AW+1:2] : req.addr[AW+1:2];
  assign arrWe    = (state == ST_RESP) && req.wr && !reqErr;
  assign arrBe    = laneMask(req.size, req.addr[1:0]);
  assign arrWData = storeSteer(req.size, req.wdata);

  data_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_ZERO   (INIT_ZERO)
  ) u_array (
    .clk   (clk),
    .we    (arrWe),
    .be    (arrBe),
    .addr  (arrAddr),
    .wdata (arrWData),
    .rdata (arrRData)
  );

  assign Ready  = (state == ST_IDLE);
  assign Busy   = (state != ST_IDLE);
  assign Done   = (state == ST_RESP);
  assign Err    = Done && reqErr;
  assign RdData = (Done && req.rd && !reqErr)
                ? loadExtend(arrRData, req.size, req.addr[1:0], req.sgn)
                : 32'h0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: a zero-wait instance and a
// three-wait-state instance driven through one access task.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic [1:0]  rstV;
  logic [31:0] addr [2];
  logic [31:0] wdat [2];
  logic [1:0]  memRd;
  logic [1:0]  memWr;
  logic [1:0]  size [2];
  logic [1:0]  sgn;
  logic [1:0]  ready;
  logic [1:0]  busy;
  logic [1:0]  done;
  logic [31:0] rdData [2];
  logic [1:0]  err;

  int nComp = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .INIT_ZERO(1'b1)) dut0 (
    .clk(clk), .rst(rstV[0]), .Address(addr[0]), .WrData(wdat[0]),
    .MemRd(memRd[0]), .MemWr(memWr[0]), .MemSize(size[0]), .MemSgn(sgn[0]),
    .Ready(ready[0]), .Busy(busy[0]), .Done(done[0]),
    .RdData(rdData[0]), .Err(err[0])
  );

  data_mem_ctrl #(.DEPTH_WORDS(64), .WAIT_STATES(3), .INIT_ZERO(1'b1)) dut1 (
    .clk(clk), .rst(rstV[1]), .Address(addr[1]), .WrData(wdat[1]),
    .MemRd(memRd[1]), .MemWr(memWr[1]), .MemSize(size[1]), .MemSgn(sgn[1]),
    .Ready(ready[1]), .Busy(busy[1]), .Done(done[1]),
    .RdData(rdData[1]), .Err(err[1])
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    nComp++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait (bounded) for Done, capture the response.
  task automatic doOp(input int d, input logic rd, input logic wr,
                      input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rdat, output logic er,
                      output int lat, output logic stallOk);
    addr[d] = a; wdat[d] = wd; size[d] = sz; sgn[d] = sg;
    memRd[d] = rd; memWr[d] = wr;
    @(posedge clk); #1;
    memRd[d] = 1'b0; memWr[d] = 1'b0;
    lat = 1; stallOk = 1'b1;
    while (!done[d] && lat < 40) begin
      if (!busy[d] || ready[d]) stallOk = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check("done_seen", {31'b0, done[d]}, 32'd1);
    if (!busy[d] || ready[d]) stallOk = 1'b0;
    rdat = rdData[d]; er = err[d];
    @(posedge clk); #1;
    check("pulse_end", {30'b0, ready[d], done[d]}, 32'b10);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        so;

    rstV = 2'b11; memRd = '0; memWr = '0; sgn = '0;
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0; wdat[i] = '0; size[i] = 2'b10;
    end
    repeat (2) @(posedge clk);
    #1;
    rstV = 2'b00;
    check("rst_flags0", {27'b0, ready[0], busy[0], done[0], err[0]}, 32'b1000);
    check("rst_rddata0", rdData[0], 32'h0);
    check("rst_flags1", {27'b0, ready[1], busy[1], done[1], err[1]}, 32'b1000);

    // zero-wait word store/load
    doOp(0, 0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, rd, er, lat, so);
    check("sw_lat", lat, 1);
    check("sw_err", {31'b0, er}, 0);
    doOp(0, 1, 0, 2'b10, 0, 32'h10, 32'h0, rd, er, lat, so);
    check("lw_data", rd, 32'hDEADBEEF);
    check("lw_lat", lat, 1);
    check("lw_stall", {31'b0, so}, 1);

    // byte store, signed/unsigned byte loads
    doOp(0, 0, 1, 2'b00, 0, 32'h13, 32'h12345680, rd, er, lat, so);
    check("sb_err", {31'b0, er}, 0);
    doOp(0, 1, 0, 2'b00, 1, 32'h13, 32'h0, rd, er, lat, so);
    check("lb_sgn", rd, 32'hFFFFFF80);
    doOp(0, 1, 0, 2'b00, 0, 32'h13, 32'h0, rd, er, lat, so);
    check("lbu", rd, 32'h00000080);
    doOp(0, 1, 0, 2'b10, 0, 32'h10, 32'h0, rd, er, lat, so);
    check("lw_after_sb", rd, 32'h80ADBEEF);
    doOp(0, 1, 0, 2'b00, 1, 32'h11, 32'h0, rd, er, lat, so);
    check("lb_lane1", rd, 32'hFFFFFFBE);

    // halfword store/load and misaligned half
    doOp(0, 0, 1, 2'b01, 0, 32'h12, 32'hAAAA1234, rd, er, lat, so);
    doOp(0, 1, 0, 2'b01, 1, 32'h12, 32'h0, rd, er, lat, so);
    check("lh_12", rd, 32'h00001234);
    doOp(0, 1, 0, 2'b01, 1, 32'h10, 32'h0, rd, er, lat, so);
    check("lh_sgn_10", rd, 32'hFFFFBEEF);
    doOp(0, 0, 1, 2'b01, 0, 32'h11, 32'h00005555, rd, er, lat, so);
    check("sh_mis_err", {31'b0, er}, 1);
    check("sh_mis_lat", lat, 1);
    doOp(0, 1, 0, 2'b10, 0, 32'h10, 32'h0, rd, er, lat, so);
    check("lw_after_mis", rd, 32'h1234BEEF);
    check("lw_ok_err", {31'b0, er}, 0);

    // error cases, none may touch memory
    doOp(0, 1, 1, 2'b10, 0, 32'h10, 32'h0, rd, er, lat, so);
    check("rdwr_err", {31'b0, er}, 1);
    doOp(0, 0, 1, 2'b11, 0, 32'h10, 32'h0, rd, er, lat, so);
    check("rsvd_err", {31'b0, er}, 1);
    doOp(0, 0, 1, 2'b10, 0, 32'h1000, 32'h0, rd, er, lat, so);
    check("range_err", {31'b0, er}, 1);
    doOp(0, 1, 0, 2'b10, 0, 32'h1000, 32'h0, rd, er, lat, so);
    check("range_ld_err", {31'b0, er}, 1);
    check("range_ld_data", rd, 32'h0);
    doOp(0, 1, 0, 2'b10, 0, 32'h12, 32'h0, rd, er, lat, so);
    check("lw_mis_err", {31'b0, er}, 1);
    doOp(0, 1, 0, 2'b10, 0, 32'h10, 32'h0, rd, er, lat, so);
    check("lw_after_errs", rd, 32'h1234BEEF);
    doOp(0, 1, 0, 2'b10, 0, 32'h0, 32'h0, rd, er, lat, so);
    check("lw_word0", rd, 32'h0);

    // last valid word
    doOp(0, 0, 1, 2'b10, 0, 32'hFFC, 32'hCAFEF00D, rd, er, lat, so);
    check("sw_top_err", {31'b0, er}, 0);
    doOp(0, 1, 0, 2'b10, 0, 32'hFFC, 32'h0, rd, er, lat, so);
    check("lw_top", rd, 32'hCAFEF00D);

    // three wait states
    doOp(1, 0, 1, 2'b10, 0, 32'h20, 32'h11111111, rd, er, lat, so);
    check("ws3_sw_lat", lat, 4);
    check("ws3_sw_stall", {31'b0, so}, 1);
    doOp(1, 1, 0, 2'b10, 0, 32'h20, 32'h0, rd, er, lat, so);
    check("ws3_lw_lat", lat, 4);
    check("ws3_lw_stall", {31'b0, so}, 1);
    check("ws3_lw_data", rd, 32'h11111111);

    // reset during WAIT drops the store
    addr[1] = 32'h20; wdat[1] = 32'h22222222; size[1] = 2'b10;
    memWr[1] = 1'b1;
    @(posedge clk); #1;
    memWr[1] = 1'b0;
    check("ws3_in_wait", {29'b0, ready[1], busy[1], done[1]}, 32'b010);
    rstV[1] = 1'b1;
    @(posedge clk); #1;
    rstV[1] = 1'b0;
    check("ws3_abort", {29'b0, ready[1], busy[1], done[1]}, 32'b100);
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("ws3_no_done", {31'b0, done[1]}, 0);
    doOp(1, 1, 0, 2'b10, 0, 32'h20, 32'h0, rd, er, lat, so);
    check("ws3_old_value", rd, 32'h11111111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
    $finish;
  end

endmodule
